ex_muldiv: RTL and testbench

- Execute-stage multiply/divide unit, directly downstream of the instruction-decode stage.
- Consumes the decoded instruction word plus the two register-file read operands (rs, rt).
- Owns the architectural HI/LO registers and executes MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI and MFLO.
- Multiply and divide are iterative, one bit per cycle. The unit raises Stall back to decode when a HI/LO instruction cannot be accepted.

---
 rtl/ex_muldiv_pkg.sv | 36 +++
 rtl/ex_muldiv_iter.sv | 53 +++++
 rtl/ex_muldiv.sv | 127 ++++++++++++
 tb/tb_ex_muldiv.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared decode constants, FSM encodings and helpers for the execute-stage multiply/divide unit.
package ex_muldiv_pkg;

    localparam int unsigned INS_W   = 32;
    localparam int unsigned COUNT_W = 5;
    localparam int unsigned ITER_LAST = 31;

    localparam logic [5:0] OP_R_FORM = 6'h00;
    localparam logic [5:0] FN_MFHI   = 6'h10;
    localparam logic [5:0] FN_MTHI   = 6'h11;
    localparam logic [5:0] FN_MFLO   = 6'h12;
    localparam logic [5:0] FN_MTLO   = 6'h13;
    localparam logic [5:0] FN_MULT   = 6'h18;
    localparam logic [5:0] FN_MULTU  = 6'h19;
    localparam logic [5:0] FN_DIV    = 6'h1A;
    localparam logic [5:0] FN_DIVU   = 6'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } md_state_t;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } md_mode_t;

    // True for any instruction that touches HI/LO.
    function automatic logic is_hilo(input logic [5:0] op, input logic [5:0] fn);
        return (op == OP_R_FORM) &&
               (fn inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
                           FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
    endfunction

endpackage

// File: rtl/ex_muldiv_iter.sv
// One-bit-per-cycle 64-bit datapath: unsigned shift-add multiply or restoring divide on magnitudes.
module ex_muldiv_iter
    import ex_muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                load,
    input  logic                step,
    input  md_mode_t            mode,
    input  logic [XLEN-1:0]     opa,
    input  logic [XLEN-1:0]     opb,
    output logic [2*XLEN-1:0]   acc
);

    logic [XLEN-1:0]   opnd;
    md_mode_t          mode_q;
    logic [XLEN:0]     sum;
    logic [XLEN:0]     diff;
    logic [2*XLEN-1:0] shl;

    // Multiply adds into the upper half; divide trials against the left-shifted upper half.
    always_comb begin
        sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd};
        shl  = {acc[2*XLEN-2:0], 1'b0};
        diff = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            acc    <= '0;
            opnd   <= '0;
            mode_q <= MODE_MUL;
        end else if (load) begin
            mode_q <= mode;
            if (mode == MODE_MUL) begin
                opnd <= opa;
                acc  <= {{XLEN{1'b0}}, opb};
            end else begin
                opnd <= opb;
                acc  <= {{XLEN{1'b0}}, opa};
            end
        end else if (step) begin
            if (mode_q == MODE_MUL) begin
                acc <= acc[0] ? {sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
            end else begin
                acc <= diff[XLEN] ? shl : {diff[XLEN-1:0], shl[XLEN-1:1], 1'b1};
            end
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Execute-stage multiply/divide unit: owns HI/LO, runs iterative MULT/DIV and stalls decode while busy.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             En,
    input  logic [INS_W-1:0] Ins,
    input  logic [XLEN-1:0]  Rdata1,
    input  logic [XLEN-1:0]  Rdata2,
    output logic [XLEN-1:0]  HiLo,
    output logic [XLEN-1:0]  HI,
    output logic [XLEN-1:0]  LO,
    output logic             Busy,
    output logic             Stall
);

    logic [5:0]          op;
    logic [5:0]          fn;
    logic                hilo_ins;
    logic                accept;
    logic                start;
    logic                signed_op;
    logic                rs_neg;
    logic                rt_neg;
    logic [XLEN-1:0]     mag_a;
    logic [XLEN-1:0]     mag_b;
    logic [2*XLEN-1:0]   acc;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quot;
    logic [XLEN-1:0]     rem;
    md_state_t           state;
    logic [COUNT_W-1:0]  count;
    logic                neg_q;
    logic                neg_r;
    logic                is_div;
    logic                div0;
    logic                unused_ins;

    assign op         = Ins[31:26];
    assign fn         = Ins[5:0];
    assign unused_ins = ^Ins[25:6];
    assign hilo_ins   = is_hilo(op, fn);
    assign Busy       = (state != ST_IDLE);
    assign Stall      = En & Busy & hilo_ins;
    assign accept     = En & hilo_ins & ~Stall;
    assign HiLo       = (fn == FN_MFHI) ? HI : LO;

    // Operand magnitudes and sign flags captured at accept.
    always_comb begin
        start     = accept & (fn inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
        signed_op = (fn == FN_MULT) || (fn == FN_DIV);
        rs_neg    = signed_op & Rdata1[XLEN-1];
        rt_neg    = signed_op & Rdata2[XLEN-1];
        mag_a     = rs_neg ? -Rdata1 : Rdata1;
        mag_b     = rt_neg ? -Rdata2 : Rdata2;
    end

    // Sign correction; the remainder path reproduces rs unchanged on divide-by-zero.
    always_comb begin
        prod = neg_q ? -acc : acc;
        rem  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        quot = div0 ? DIV0_QUOT : (neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0]);
    end

    ex_muldiv_iter #(.XLEN(XLEN)) u_iter (
        .CLK  (CLK),
        .RST  (RST),
        .load (start),
        .step (state == ST_CALC),
        .mode (fn[1] ? MODE_DIV : MODE_MUL),
        .opa  (mag_a),
        .opb  (mag_b),
        .acc  (acc)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state  <= ST_IDLE;
            HI     <= '0;
            LO     <= '0;
            count  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            is_div <= 1'b0;
            div0   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        is_div <= fn[1];
                        neg_q  <= rs_neg ^ rt_neg;
                        neg_r  <= rs_neg;
                        div0   <= fn[1] & (Rdata2 == '0);
                        count  <= '0;
                        state  <= ST_CALC;
                    end else if (accept && fn == FN_MTHI) begin
                        HI <= Rdata1;
                    end else if (accept && fn == FN_MTLO) begin
                        LO <= Rdata1;
                    end
                end
                ST_CALC: begin
                    count <= count + COUNT_W'(1);
                    if (count == COUNT_W'(ITER_LAST)) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (is_div) begin
                        HI <= rem;
                        LO <= quot;
                    end else begin
                        HI <= prod[2*XLEN-1:XLEN];
                        LO <= prod[XLEN-1:0];
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: expected HI/LO queued at issue, compared when Busy falls.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        En = 1'b0;
    logic [31:0] Ins = 32'h0;
    logic [31:0] Rdata1 = 32'h0;
    logic [31:0] Rdata2 = 32'h0;
    logic [31:0] HiLo, HI, LO;
    logic        Busy, Stall;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] sb[$];

    ex_muldiv dut (
        .CLK(CLK), .RST(RST), .En(En), .Ins(Ins), .Rdata1(Rdata1), .Rdata2(Rdata2),
        .HiLo(HiLo), .HI(HI), .LO(LO), .Busy(Busy), .Stall(Stall)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mk(input logic [5:0] fn);
        return {OP_R_FORM, 20'h0, fn};
    endfunction

    // Reference {HI,LO} computed with native 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sbv, q, r;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        case (fn)
            FN_MULT:  return 64'(sa * sbv);
            FN_MULTU: return {32'h0, a} * {32'h0, b};
            FN_DIV: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                q = sa / sbv;
                r = sa % sbv;
                return {r[31:0], q[31:0]};
            end
            FN_DIVU: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'h0;
        endcase
    endfunction

    // Called just after a negedge; returns just after the negedge where Busy is first low.
    task automatic run_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                          output int cyc, output bit stall_seen);
        En = 1'b1; Ins = mk(fn); Rdata1 = a; Rdata2 = b;
        sb.push_back(model(fn, a, b));
        @(negedge CLK);
        Ins = {6'h23, 26'h0};
        cyc = 0;
        stall_seen = 1'b0;
        while (Busy === 1'b1 && cyc < 100) begin
            Rdata1 = $urandom;
            Rdata2 = $urandom;
            #1;
            if (Stall !== 1'b0) stall_seen = 1'b1;
            cyc++;
            @(negedge CLK);
        end
        En = 1'b0; Ins = 32'h0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK);
        n_cmp++; if (HI !== 32'h0) begin n_bad++; $display("FAIL reset_hi got %h want 0", HI); end
        n_cmp++; if (LO !== 32'h0) begin n_bad++; $display("FAIL reset_lo got %h want 0", LO); end
        n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", Busy); end
        n_cmp++; if (Stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b want 0", Stall); end
        RST = 1'b1;
    endtask

    task automatic test_mult();
        int cyc; bit st; logic [63:0] exp;
        run_op(FN_MULT, 32'd7, 32'hFFFF_FFFD, cyc, st);
        exp = sb.pop_front();
        n_cmp++; if (cyc != 33) begin n_bad++; $display("FAIL mult_busy_len got %0d want 33", cyc); end
        n_cmp++; if ({HI, LO} !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_bad++; $display("FAIL mult_7x-3 got %h want ffffffffffffffeb", {HI, LO}); end
        n_cmp++; if ({HI, LO} !== exp) begin n_bad++; $display("FAIL mult_sb got %h want %h", {HI, LO}, exp); end
        n_cmp++; if (st) begin n_bad++; $display("FAIL nonhilo_stall got 1 want 0"); end
        run_op(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, st);
        exp = sb.pop_front();
        n_cmp++; if ({HI, LO} !== 64'hFFFF_FFFE_0000_0001) begin n_bad++; $display("FAIL multu_max got %h want fffffffe00000001", {HI, LO}); end
        n_cmp++; if ({HI, LO} !== exp) begin n_bad++; $display("FAIL multu_sb got %h want %h", {HI, LO}, exp); end
    endtask

    task automatic test_div();
        int cyc; bit st; logic [63:0] exp;
        run_op(FN_DIV, 32'hFFFF_FFF9, 32'd2, cyc, st);
        exp = sb.pop_front();
        n_cmp++; if ({HI, LO} !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_bad++; $display("FAIL div_-7/2 got %h want fffffffffffffffd", {HI, LO}); end
        n_cmp++; if ({HI, LO} !== exp) begin n_bad++; $display("FAIL div_sb got %h want %h", {HI, LO}, exp); end
        run_op(FN_DIVU, 32'd7, 32'd0, cyc, st);
        exp = sb.pop_front();
        n_cmp++; if (cyc != 33) begin n_bad++; $display("FAIL div0_busy_len got %0d want 33", cyc); end
        n_cmp++; if ({HI, LO} !== 64'h0000_0007_FFFF_FFFF) begin n_bad++; $display("FAIL divu_by0 got %h want 00000007ffffffff", {HI, LO}); end
        run_op(FN_DIV, 32'hFFFF_FF00, 32'd0, cyc, st);
        exp = sb.pop_front();
        n_cmp++; if ({HI, LO} !== exp) begin n_bad++; $display("FAIL div_neg_by0 got %h want %h", {HI, LO}, exp); end
        run_op(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc, st);
        exp = sb.pop_front();
        n_cmp++; if ({HI, LO} !== 64'h0000_0000_8000_0000) begin n_bad++; $display("FAIL div_overflow got %h want 0000000080000000", {HI, LO}); end
    endtask

    task automatic test_stall_mflo();
        int guard; bit stall_bad; logic [63:0] exp;
        En = 1'b1; Ins = mk(FN_DIV); Rdata1 = 32'd100; Rdata2 = 32'd7;
        sb.push_back(model(FN_DIV, 32'd100, 32'd7));
        @(negedge CLK);
        En = 1'b0; Ins = 32'h0;
        @(negedge CLK);
        En = 1'b1; Ins = mk(FN_MFLO);
        guard = 0; stall_bad = 1'b0;
        #1;
        while (Busy === 1'b1 && guard < 100) begin
            if (Stall !== 1'b1) stall_bad = 1'b1;
            guard++;
            @(negedge CLK); #1;
        end
        exp = sb.pop_front();
        n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL mflo_timeout busy got %b want 0", Busy); end
        n_cmp++; if (stall_bad) begin n_bad++; $display("FAIL mflo_stall_while_busy got 0 want 1"); end
        n_cmp++; if (Stall !== 1'b0) begin n_bad++; $display("FAIL mflo_stall_after got %b want 0", Stall); end
        n_cmp++; if (HiLo !== 32'd14) begin n_bad++; $display("FAIL mflo_value got %0d want 14", HiLo); end
        n_cmp++; if ({HI, LO} !== exp) begin n_bad++; $display("FAIL div100_7_sb got %h want %h", {HI, LO}, exp); end
        @(negedge CLK);
        En = 1'b0; Ins = 32'h0;
    endtask

    task automatic test_mthi_stall();
        int guard; logic [63:0] exp;
        En = 1'b1; Ins = mk(FN_MULT); Rdata1 = 32'd2; Rdata2 = 32'd3;
        sb.push_back(model(FN_MULT, 32'd2, 32'd3));
        @(negedge CLK);
        Ins = mk(FN_MTHI); Rdata1 = 32'h55; Rdata2 = 32'h0;
        guard = 0;
        #1;
        while (Busy === 1'b1 && guard < 100) begin
            guard++;
            @(negedge CLK); #1;
        end
        exp = sb.pop_front();
        n_cmp++; if ({HI, LO} !== exp) begin n_bad++; $display("FAIL mthi_no_early_write got %h want %h", {HI, LO}, exp); end
        @(negedge CLK);
        Ins = mk(FN_MFHI);
        #1;
        n_cmp++; if (HI !== 32'h55) begin n_bad++; $display("FAIL mthi_after_busy got %h want 55", HI); end
        n_cmp++; if (HiLo !== 32'h55) begin n_bad++; $display("FAIL mfhi_back_to_back got %h want 55", HiLo); end
        @(negedge CLK);
        En = 1'b0; Ins = 32'h0;
    endtask

    task automatic test_reset_abort();
        int cyc; bit st; logic [63:0] exp;
        En = 1'b1; Ins = mk(FN_MULT); Rdata1 = 32'h1234_5678; Rdata2 = 32'h9ABC_DEF0;
        @(negedge CLK);
        En = 1'b0; Ins = 32'h0;
        repeat (9) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", Busy); end
        n_cmp++; if ({HI, LO} !== 64'h0) begin n_bad++; $display("FAIL abort_hilo got %h want 0", {HI, LO}); end
        RST = 1'b1;
        run_op(FN_MULT, 32'd3, 32'd4, cyc, st);
        exp = sb.pop_front();
        n_cmp++; if ({HI, LO} !== 64'd12) begin n_bad++; $display("FAIL mult_after_abort got %h want c", {HI, LO}); end
        n_cmp++; if ({HI, LO} !== exp) begin n_bad++; $display("FAIL mult_after_abort_sb got %h want %h", {HI, LO}, exp); end
    endtask

    task automatic test_back_to_back();
        int cyc; bit st; logic [63:0] exp;
        logic [5:0] fns[4];
        logic [5:0] f;
        logic [31:0] a, b;
        fns[0] = FN_MULT; fns[1] = FN_MULTU; fns[2] = FN_DIV; fns[3] = FN_DIVU;
        for (int i = 0; i < 8; i++) begin
            f = fns[$urandom_range(3, 0)];
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(20, 0)) - 32'd10 : $urandom;
            run_op(f, a, b, cyc, st);
            exp = sb.pop_front();
            n_cmp++; if (cyc != 33) begin n_bad++; $display("FAIL b2b_busy_len[%0d] got %0d want 33", i, cyc); end
            n_cmp++; if ({HI, LO} !== exp) begin n_bad++; $display("FAIL b2b_result[%0d] fn %h a %h b %h got %h want %h", i, f, a, b, {HI, LO}, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_stall_mflo();
        test_mthi_stall();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
